usr_sequencer: RTL and testbench
================================

Name: usr_sequencer

Overview:
Command sequencer that sits directly upstream of the universal shift register's per-bit 4:1 select muxes. It accepts one command at a time over a valid/ready handshake and drives the shared select[1:0] bus for the programmed number of cycles. It also drives the boundary serial-in bits and the parallel-load word into the register's mux inputs, and pulses done when the command completes.

Parameters:
WIDTH, 4, register width in bits; legal range 2 to 32.
CNT_W, 6, width of the shift-count field; the maximum count per command is 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command (IDLE only)
cmd_op  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
cmd_count  input  CNT_W  number of shift cycles; ignored for hold and load
cmd_fill  input  1  serial bit shifted into the vacated end
cmd_data  input  WIDTH  parallel-load word
abort  input  1  cancel the active command
select  output  2  mux control S1,S0 to every bit slice
msb_serial_in  output  1  shift-right input of the MSB slice
lsb_serial_in  output  1  shift-left input of the LSB slice
par_data  output  WIDTH  parallel_load inputs of the slices
busy  output  1  command in progress
done  output  1  one-cycle pulse on the last active cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - select=00, msb_serial_in=0, lsb_serial_in=0, par_data=0, busy=0, done=0, cmd_ready=1.
  - Reset takes priority over abort and the handshake. An in-flight command is dropped without done.
- All outputs are registered. cmd_ready=1 exactly when the state is IDLE.
- Accept: cmd_valid & cmd_ready at edge T latches op, count, fill and data. Input values at any other time are ignored.
- States:
  - IDLE: select=00 (hold), busy=0. On accept, go to LOAD for op 11, SHIFT for op 01/10 with count>0, or ONE for op 00, or op 01/10 with count=0.
  - LOAD: one cycle, T+1. select=11, par_data=latched data, done=1. Then IDLE.
  - ONE: one cycle, T+1. select=00, done=1. Then IDLE. This is a no-op completion.
  - SHIFT: cycles T+1 through T+N, where N=count.
    - select=op.
    - For op 01: msb_serial_in=fill; lsb_serial_in=0.
    - For op 10: lsb_serial_in=fill; msb_serial_in=0.
    - An internal down-counter is loaded with N at accept and decrements each SHIFT cycle.
    - done=1 in the cycle where the remaining count is 1. Then IDLE.
- busy=1 in LOAD, ONE and SHIFT.
- The next command can be accepted at the first edge with cmd_ready=1, i.e. at T+N+1 for a shift. Back-to-back commands leave exactly one IDLE (select=00) cycle between them.
- Abort:
  - abort=1 at an edge while busy: the next cycle is IDLE, select=00, no done pulse, counter cleared.
  - abort in IDLE has no effect, and the same-edge handshake is still accepted.
  - If abort and the final SHIFT edge coincide, done has already been asserted in that cycle; the return to IDLE is unchanged.
- Counts above WIDTH are legal: the register shifts fill bits in repeatedly. No clamping.
- Outside the shift and load states, serial and par_data outputs return to 0.
- Select encoding is fixed: 00 hold, 01 shift right, 10 shift left, 11 parallel load.

Decomposition:
- Package usr_pkg holds:
  - select/op constants: SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
  - the state enum: IDLE, LOAD, ONE, SHIFT.
- One sub-module, usr_shift_counter: a loadable CNT_W-bit down-counter with load, dec, clr inputs and a last (==1) flag.

Test Plan:
- Reset: hold rst 2 cycles mid-SHIFT (count=5, cycle 2) -> next cycle select=00, busy=0, cmd_ready=1, no done.
- Parallel load: WIDTH=4, op=11, data=4'b1011 at edge T -> cycle T+1: select=11, par_data=1011, done=1; T+2: select=00, cmd_ready=1.
- Shift right: op=01, count=3, fill=1 -> select=01 and msb_serial_in=1 for exactly 3 cycles, done on the 3rd only. A downstream model of the register starting at 0000 reads 1110.
- Shift left: op=10, count=0 -> one cycle with select=00, done=1, busy=1. Then ready again.
- Abort: op=10, count=6; assert abort at the 3rd SHIFT cycle -> next cycle select=00, no done. A new load command is accepted on the following edge.
- Back-to-back: cmd_valid held high with shift-left count=2 then load 4'b0101 -> select sequence 10,10,00,11,00; two done pulses.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer:
// select/op encodings, FSM state type and a small op classifier.
package usr_pkg;

   localparam int unsigned SEL_W = 2;

   // Select encoding driven to every bit slice; commands use the same codes.
   localparam logic [SEL_W-1:0] SEL_HOLD = 2'b00;
   localparam logic [SEL_W-1:0] SEL_SHR  = 2'b01;
   localparam logic [SEL_W-1:0] SEL_SHL  = 2'b10;
   localparam logic [SEL_W-1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ONE   = 2'd2,
      SHIFT = 2'd3
   } state_t;

   // True for the two ops that consume a shift count.
   function automatic logic is_shift_op(input logic [SEL_W-1:0] op);
      return (op == SEL_SHR) || (op == SEL_SHL);
   endfunction

endpackage

// File: rtl/usr_sequencer_if.sv
// Command handshake bundle for usr_sequencer.
//   cmd_valid/cmd_ready : valid/ready handshake
//   cmd_op              : 00 hold, 01 shift right, 10 shift left, 11 load
//   cmd_count           : shift cycles (ignored for hold/load)
//   cmd_fill            : serial bit shifted into the vacated end
//   cmd_data            : parallel-load word
// master = command issuer, slave = sequencer.
interface usr_sequencer_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 6
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic             cmd_fill;
   logic [WIDTH-1:0] cmd_data;

   modport master (
      output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/usr_shift_counter.sv
// Loadable down-counter tracking the remaining shift cycles.
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_val (priority below clr)
//   dec         : decrement by one (saturates at zero)
//   clr         : clear to zero (highest priority)
//   last        : current value == 1
//   last_next_c : value after the coming edge will be 1 (combinational)
module usr_shift_counter #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic             clr,
   input  logic [CNT_W-1:0] load_val,
   output logic             last,
   output logic             last_next_c
);

   logic [CNT_W-1:0] count_q;

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign last = (count_q == CNT_W'(1));

   // Look-ahead so the registered done can line up with the final shift cycle.
   always_comb begin
      last_next_c = 1'b0;
      if (clr) begin
         last_next_c = 1'b0;
      end else if (load) begin
         last_next_c = (load_val == CNT_W'(1));
      end else if (dec) begin
         last_next_c = (count_q == CNT_W'(2));
      end else begin
         last_next_c = last;
      end
   end

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer in front of a universal shift register's per-bit
// 4:1 select muxes. Accepts one command at a time and drives select,
// boundary serial inputs and the parallel-load word; pulses done on
// the final active cycle.
//   clk, rst       : clock, synchronous active-high reset
//   cmd            : command handshake (usr_sequencer_if.slave)
//   abort          : cancel the active command
//   select         : mux control S1,S0 to every slice
//   msb_serial_in  : shift-right input of the MSB slice
//   lsb_serial_in  : shift-left input of the LSB slice
//   par_data       : parallel-load inputs of the slices
//   busy           : command in progress
//   done           : one-cycle pulse on the last active cycle
// All outputs are registered; output values are computed from the
// next state so they change on the same edge as the state.
module usr_sequencer
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   usr_sequencer_if.slave   cmd,
   input  logic             abort,
   output logic [1:0]       select,
   output logic             msb_serial_in,
   output logic             lsb_serial_in,
   output logic [WIDTH-1:0] par_data,
   output logic             busy,
   output logic             done
);

   state_t state_q, state_d;

   logic             ready_q;
   logic             accept;

   logic [1:0]       op_q;
   logic             fill_q;
   logic [WIDTH-1:0] data_q;

   logic [1:0]       cur_op;
   logic             cur_fill;
   logic [WIDTH-1:0] cur_data;

   logic             cnt_load, cnt_dec, cnt_clr;
   logic             cnt_last, cnt_last_next;

   logic [1:0]       select_d;
   logic             msb_d, lsb_d;
   logic [WIDTH-1:0] par_d;
   logic             busy_d, done_d, ready_d;

   assign accept        = cmd.cmd_valid && ready_q;
   assign cmd.cmd_ready = ready_q;

   // On the accept edge the latched fields are not yet valid, so bypass them.
   assign cur_op   = accept ? cmd.cmd_op   : op_q;
   assign cur_fill = accept ? cmd.cmd_fill : fill_q;
   assign cur_data = accept ? cmd.cmd_data : data_q;

   // Command latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= SEL_HOLD;
         fill_q <= 1'b0;
         data_q <= '0;
      end else if (accept) begin
         op_q   <= cmd.cmd_op;
         fill_q <= cmd.cmd_fill;
         data_q <= cmd.cmd_data;
      end
   end

   // Abort only clears while busy; in IDLE it must not disturb an accept.
   assign cnt_load = accept;
   assign cnt_dec  = (state_q == SHIFT) && !abort;
   assign cnt_clr  = (state_q != IDLE) && abort;

   usr_shift_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .load        (cnt_load),
      .dec         (cnt_dec),
      .clr         (cnt_clr),
      .load_val    (cmd.cmd_count),
      .last        (cnt_last),
      .last_next_c (cnt_last_next)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd.cmd_op == SEL_LOAD) begin
                  state_d = LOAD;
               end else if (is_shift_op(cmd.cmd_op) && (cmd.cmd_count != '0)) begin
                  state_d = SHIFT;
               end else begin
                  state_d = ONE;
               end
            end
         end
         LOAD:    state_d = IDLE;
         ONE:     state_d = IDLE;
         SHIFT: begin
            if (abort || cnt_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: values for the cycle that begins at the next edge.
   always_comb begin
      select_d = SEL_HOLD;
      msb_d    = 1'b0;
      lsb_d    = 1'b0;
      par_d    = '0;
      done_d   = 1'b0;
      ready_d  = (state_d == IDLE);
      busy_d   = (state_d != IDLE);
      case (state_d)
         LOAD: begin
            select_d = SEL_LOAD;
            par_d    = cur_data;
            done_d   = 1'b1;
         end
         ONE: begin
            done_d = 1'b1;
         end
         SHIFT: begin
            select_d = cur_op;
            msb_d    = (cur_op == SEL_SHR) && cur_fill;
            lsb_d    = (cur_op == SEL_SHL) && cur_fill;
            done_d   = cnt_last_next;
         end
         default: begin
            select_d = SEL_HOLD;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         select        <= SEL_HOLD;
         msb_serial_in <= 1'b0;
         lsb_serial_in <= 1'b0;
         par_data      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         select        <= select_d;
         msb_serial_in <= msb_d;
         lsb_serial_in <= lsb_d;
         par_data      <= par_d;
         busy          <= busy_d;
         done          <= done_d;
         ready_q       <= ready_d;
      end
   end

endmodule

// File: tb/tb_usr_sequencer.sv
// Scoreboard bench for usr_sequencer: driver pushes expected per-cycle
// beats on accept, a negedge monitor pops and compares; a downstream
// universal shift register model is compared against a closed-form result.
module tb_usr_sequencer;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 6;

   typedef struct {
      logic [1:0]   sel;
      logic         msb;
      logic         lsb;
      logic [W-1:0] par;
      logic         done;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          abort;
   logic [1:0]    select;
   logic          msb_serial_in, lsb_serial_in;
   logic [W-1:0]  par_data;
   logic          busy, done;

   usr_sequencer_if #(.WIDTH(W), .CNT_W(CW)) cif ();

   usr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cif),
      .abort         (abort),
      .select        (select),
      .msb_serial_in (msb_serial_in),
      .lsb_serial_in (lsb_serial_in),
      .par_data      (par_data),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   beat_t        exp_q[$];
   beat_t        mon_b;
   logic [W-1:0] exp_reg = '0;
   logic [W-1:0] reg_before;
   logic [W-1:0] sreg;
   logic [1:0]   s_op;
   logic         s_fill;
   logic [W-1:0] s_data;
   int           s_cnt;
   int           last_acc = 0;
   int           last_len = 0;
   bit           last_aborted = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream universal shift register driven by the sequencer.
   always @(posedge clk) begin
      if (rst) sreg <= '0;
      else begin
         case (select)
            2'b01:   sreg <= {msb_serial_in, sreg[W-1:1]};
            2'b10:   sreg <= {sreg[W-2:0], lsb_serial_in};
            2'b11:   sreg <= par_data;
            default: sreg <= sreg;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Register contents after k applied cycles of a command.
   function automatic logic [W-1:0] apply(input logic [W-1:0] r, input logic [1:0] op,
                                          input int k, input logic fill, input logic [W-1:0] d);
      logic [W-1:0] ones;
      ones = '1;
      if (k == 0) return r;
      case (op)
         2'b11:   return d;
         2'b01:   return (k >= int'(W)) ? {W{fill}} : ((r >> k) | (fill ? ~(ones >> k) : '0));
         2'b10:   return (k >= int'(W)) ? {W{fill}} : ((r << k) | (fill ? ~(ones << k) : '0));
         default: return r;
      endcase
   endfunction

   // Monitor: every busy cycle consumes one expected beat; idle cycles are quiet.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat: got select=%0b done=%0b expected no busy cycle", select, done);
            end else begin
               mon_b = exp_q.pop_front();
               chk("beat_select", 64'(select), 64'(mon_b.sel));
               chk("beat_serial", 64'({msb_serial_in, lsb_serial_in}), 64'({mon_b.msb, mon_b.lsb}));
               chk("beat_par", 64'(par_data), 64'(mon_b.par));
               chk("beat_done", 64'(done), 64'(mon_b.done));
               chk("beat_ready", 64'(cif.cmd_ready), 64'(0));
            end
         end else begin
            chk("idle_outputs", 64'({select, msb_serial_in, lsb_serial_in, par_data, done, cif.cmd_ready}),
                64'({2'b00, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b1}));
            chk("idle_no_pending", 64'(exp_q.size()), 64'(0));
            chk("idle_register", 64'(sreg), 64'(exp_reg));
         end
      end
   end

   task automatic send(input logic [1:0] op, input int cnt, input logic fill,
                       input logic [W-1:0] data, input bit idle_abort, input bit chk_b2b);
      int    waited;
      bit    ok;
      int    len;
      beat_t b;
      cif.cmd_op    = op;
      cif.cmd_count = CW'(cnt);
      cif.cmd_fill  = fill;
      cif.cmd_data  = data;
      cif.cmd_valid = 1'b1;
      waited = 0;
      ok = 0;
      while (!ok && waited < 300) begin
         @(negedge clk);
         if (cif.cmd_ready) begin
            if (idle_abort) abort = 1'b1;
            @(posedge clk);
            ok = 1;
         end else waited++;
      end
      #1;
      cif.cmd_valid = 1'b0;
      abort = 1'b0;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
         return;
      end
      if (chk_b2b) chk("b2b_accept_cycle", 64'(cyc), 64'(last_acc + last_len + 1));
      reg_before = exp_reg;
      s_op = op; s_fill = fill; s_data = data; s_cnt = cnt;
      if (op == 2'b11) begin
         b = '{sel: 2'b11, msb: 1'b0, lsb: 1'b0, par: data, done: 1'b1};
         exp_q.push_back(b);
         len = 1;
         exp_reg = apply(exp_reg, op, 1, fill, data);
      end else if (op == 2'b00 || cnt == 0) begin
         b = '{sel: 2'b00, msb: 1'b0, lsb: 1'b0, par: '0, done: 1'b1};
         exp_q.push_back(b);
         len = 1;
      end else begin
         for (int i = 0; i < cnt; i++) begin
            b = '{sel: op, msb: (op == 2'b01) ? fill : 1'b0, lsb: (op == 2'b10) ? fill : 1'b0,
                  par: '0, done: (i == cnt - 1)};
            exp_q.push_back(b);
         end
         len = cnt;
         exp_reg = apply(exp_reg, op, cnt, fill, data);
      end
      last_acc = cyc;
      last_len = len;
   endtask

   // Abort during the k-th active cycle of the command just accepted.
   task automatic abort_at(input int k);
      int applied;
      repeat (k - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      applied = last_len - exp_q.size();
      if (s_op == 2'b11) exp_reg = apply(reg_before, s_op, applied, s_fill, s_data);
      else if (s_op == 2'b00 || s_cnt == 0) exp_reg = reg_before;
      else exp_reg = apply(reg_before, s_op, applied, s_fill, s_data);
      exp_q.delete();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      exp_reg = '0;
   endtask

   initial begin
      int gap;
      bit ia;
      rst = 1'b1;
      abort = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_op = 2'b00;
      cif.cmd_count = '0;
      cif.cmd_fill = 1'b0;
      cif.cmd_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the 2nd cycle of a 5-cycle shift.
      send(2'b01, 5, 1'b1, '0, 0, 0);
      @(posedge clk); #1;
      do_reset(2);
      repeat (2) @(posedge clk); #1;

      // Shift right 3 with fill 1 from 0000, then parallel load 1011.
      send(2'b01, 3, 1'b1, '0, 0, 0);
      repeat (5) @(posedge clk); #1;
      chk("shr3_register", 64'(sreg), 64'(4'b1110));
      send(2'b11, 0, 1'b0, 4'b1011, 0, 0);
      repeat (3) @(posedge clk); #1;

      // Shift left with count 0 is a one-cycle no-op completion.
      send(2'b10, 0, 1'b1, '0, 0, 0);
      repeat (3) @(posedge clk); #1;

      // Abort at the 3rd cycle of a 6-cycle shift, then an immediate load.
      send(2'b10, 6, 1'b1, '0, 0, 0);
      abort_at(3);
      send(2'b11, 0, 1'b0, 4'b0110, 0, 0);
      chk("post_abort_accept", 64'(cyc - last_acc + 1), 64'(1));
      repeat (3) @(posedge clk); #1;

      // Back-to-back: shift left 2 then load 0101 with valid held high.
      send(2'b10, 2, 1'b0, '0, 0, 0);
      send(2'b11, 0, 1'b0, 4'b0101, 0, 1);
      repeat (3) @(posedge clk); #1;

      // Randomized commands, gaps, aborts and idle-time aborts.
      last_aborted = 1;
      for (int i = 0; i < 150; i++) begin
         gap = $urandom_range(0, 2);
         ia  = (gap > 0) && ($urandom_range(0, 3) == 0);
         repeat (gap) @(posedge clk);
         if (gap > 0) #1;
         send(2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), ia, (gap == 0) && !last_aborted);
         if ($urandom_range(0, 7) == 0) begin
            abort_at(int'($urandom_range(1, last_len)));
            last_aborted = 1;
         end else begin
            last_aborted = 0;
         end
         if ($urandom_range(0, 49) == 0) begin
            do_reset(1);
            last_aborted = 1;
         end
      end

      repeat (80) @(posedge clk);
      #1;
      chk("final_drain", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
